popcnt_shift_accumulator: RTL and testbench
===========================================

Name: popcnt_shift_accumulator

Overview:
- Downstream consumer of the 15-to-4 popcount compressor in the bit-serial MAC path.
- Each accepted beat carries one 4-bit popcount (0..15) for one activation/weight bit-plane pair.
- The block weights each count by 2^shift, adds or subtracts it (subtract for sign planes), and accumulates over a frame delimited by first/last flags.
- At frame end it presents one signed dot-product partial sum through a single-entry output register with valid/ready handshake.

Parameters:
- ACC_W, 24, accumulator and result width (signed, two's complement); must be >= 4 + 2^SHIFT_W.
- SHIFT_W, 4, width of the plane-weight shift amount (shift range 0..2^SHIFT_W-1).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat present.
- in_ready  output  1  beat can be accepted.
- in_cnt  input  4  popcount {O3,O2,O1,O0} from the compressor, 0..15.
- in_shift  input  SHIFT_W  plane weight exponent.
- in_neg  input  1  1 = subtract term (sign plane), 0 = add.
- in_first  input  1  first beat of a frame.
- in_last  input  1  last beat of a frame (may coincide with in_first).
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  signed frame result.
- out_ovf  output  1  signed overflow occurred in at least one add of that frame; qualified by out_valid.
- err_frame  output  1  one-cycle pulse: protocol error (beat without in_first while no frame is open).

Behaviour:
- Reset (async, reset_n=0):
  - acc=0; state=IDLE; out_valid=0; out_data=0; out_ovf=0; err_frame=0; frame overflow flag cleared.
  - A frame in progress is discarded.
  - in_ready = 1 after reset.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = !out_valid | out_ready, independent of in_valid (no combinational path from in_valid).
  - Holding a beat back while out_valid=1 and out_ready=0 applies to all beats, not only last beats. This keeps the control simple and lossless.
- Term:
  - T = zero_extend(in_cnt) << in_shift, ACC_W bits.
  - Effective term is +T or -T (per in_neg).
- States:
  - IDLE: no frame open.
  - ACCUM: frame open.
- Accepted beat with in_first=1, any state:
  - base = 0 (any open frame is silently restarted; no error).
  - frame overflow flag reset.
- Accepted beat with in_first=0 in ACCUM:
  - base = acc.
- Accepted beat with in_first=0 in IDLE:
  - base = 0, treated as a first beat.
  - err_frame pulses high for exactly one cycle.
- New sum:
  - new = base ± T, wrapping ACC_W-bit arithmetic.
  - Signed overflow on this add is OR-ed into the frame flag.
- Non-last beat: acc <= new; state <= ACCUM.
- Last beat (in_last=1):
  - out_data <= new; out_ovf <= frame flag incl. this add; out_valid <= 1.
  - acc <= 0; state <= IDLE.
  - Latency: result visible the cycle after the last beat is accepted.
- Output transfer without a new last beat in the same cycle:
  - out_valid <= 0.
  - out_data/out_ovf hold their last values.
- Simultaneous output transfer and last-beat acceptance:
  - The new result loads; out_valid stays 1.
  - Full throughput: single-beat frames at 1 result/cycle.
- Stall:
  - out_valid=1 with out_ready=0 holds out_data stable and forces in_ready=0.
  - The accumulator and state are frozen.
- Cycles with in_valid=0 leave all state unchanged, including mid-frame.

Test Plan:
- Reset, then frame of 8 beats, cnt=15 and shift=0..7, in_neg=1 only on shift=7, out_ready=1 -> out_data = 15*(127-128) = -15, out_valid for 1 cycle, out_ovf=0.
- Single-beat frames (first=last=1) on consecutive cycles, cnt=1,2,3, out_ready=1 -> results 1,2,3 on consecutive cycles; in_ready stays 1.
- Frame cnt=5/shift=2 then cnt=3/shift=0 (last) with out_ready=0 for 4 cycles -> out_data=23 held stable; in_ready=0 throughout the stall; the next beat is accepted the cycle out_ready rises.
- ACC_W=24: two beats cnt=15, shift=15, in_neg=0 -> 2*491520 = 983040 fits, ovf=0. Repeat with 18 beats (8847360 > 2^23-1) -> result wraps, out_ovf=1. The following clean frame -> out_ovf=0.
- Beat with first=0 while IDLE (cnt=4, shift=1, last=1) -> err_frame pulses 1 cycle, out_data=8. Second case: mid-frame first=1 -> accumulation restarts, err_frame stays 0.
- Assert reset_n low mid-frame and while out_valid=1 -> out_valid=0 immediately (asynchronously). A post-reset frame cnt=2/shift=0 gives out_data=2 (no stale accumulation).

Source files
------------

// File: rtl/popcnt_shift_accumulator.sv
// Weighted popcount accumulator for the bit-serial MAC path: each beat adds or
// subtracts cnt<<shift, and a frame's signed sum is returned through one output register.
module popcnt_shift_accumulator #(
  parameter int ACC_W   = 24,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_cnt,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_neg,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_ovf,
  output logic               err_frame
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum_new;
  logic             frame_ovf;
  logic             flag_base;
  logic             add_ovf;
  logic             fresh;
  logic             accept;

  // Valid/ready: a beat moves when in_valid & in_ready, a result when
  // out_valid & out_ready. in_ready never looks at in_valid, and any beat
  // (not only a last one) waits while a result is stalled.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A beat outside an open frame starts a new one even without in_first.
  assign fresh = in_first || (state == IDLE);
  assign term  = {{(ACC_W-4){1'b0}}, in_cnt} << in_shift;

  always_comb begin
    base      = fresh ? '0 : acc;
    flag_base = fresh ? 1'b0 : frame_ovf;
    sum_new   = in_neg ? (base - term) : (base + term);
    if (in_neg)
      add_ovf = (base[ACC_W-1] != term[ACC_W-1]) && (sum_new[ACC_W-1] != base[ACC_W-1]);
    else
      add_ovf = (base[ACC_W-1] == term[ACC_W-1]) && (sum_new[ACC_W-1] != base[ACC_W-1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      frame_ovf <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= accept && !in_first && (state == IDLE);
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (in_last) begin
          out_data  <= sum_new;
          out_ovf   <= flag_base || add_ovf;
          out_valid <= 1'b1;
          acc       <= '0;
          frame_ovf <= 1'b0;
          state     <= IDLE;
        end else begin
          acc       <= sum_new;
          frame_ovf <= flag_base || add_ovf;
          state     <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcnt_shift_accumulator.sv
// Directed bench for popcnt_shift_accumulator: hand-computed frame results are
// queued as expectations and matched against every output transfer.
module tb_popcnt_shift_accumulator;

  localparam int ACC_W   = 24;
  localparam int SHIFT_W = 4;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_cnt;
  logic [SHIFT_W-1:0] in_shift;
  logic               in_neg;
  logic               in_first;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic               out_ovf;
  logic               err_frame;

  int n_checks = 0;
  int n_errors = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic             ovf_q[$];
  logic [ACC_W-1:0] mon_data;
  logic             mon_ovf;

  popcnt_shift_accumulator #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .in_shift  (in_shift),
    .in_neg    (in_neg),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .err_frame (err_frame)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int value, input logic ovf);
    logic [31:0] v;
    v = value;
    exp_q.push_back(v[ACC_W-1:0]);
    ovf_q.push_back(ovf);
  endtask

  // driver: called just after a rising edge, returns just after the accepting edge
  task automatic send(input int cnt, input int shift, input logic neg,
                      input logic first, input logic last);
    logic [31:0] c;
    logic [31:0] s;
    int guard;
    c = cnt;
    s = shift;
    guard = 0;
    in_valid = 1'b1;
    in_cnt   = c[3:0];
    in_shift = s[SHIFT_W-1:0];
    in_neg   = neg;
    in_first = first;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: every output transfer must match the head of the queue
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_data = exp_q.pop_front();
        mon_ovf  = ovf_q.pop_front();
        check("out_data", out_data, mon_data);
        check("out_ovf", out_ovf, mon_ovf);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_cnt    = '0;
    in_shift  = '0;
    in_neg    = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_ovf", out_ovf, 32'd0);
    check("rst_err_frame", err_frame, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;

    // 15*(1+..+64) - 15*128 = -15
    push_exp(-15, 1'b0);
    for (int s = 0; s < 8; s++)
      send(15, s, (s == 7), (s == 0), (s == 7));
    check("f1_valid_on", out_valid, 32'd1);
    @(posedge clk);
    #1;
    check("f1_valid_off", out_valid, 32'd0);

    // back-to-back single-beat frames
    for (int i = 1; i <= 3; i++) begin
      push_exp(i, 1'b0);
      send(i, 0, 1'b0, 1'b1, 1'b1);
      check("single_valid", out_valid, 32'd1);
      check("single_in_ready", in_ready, 32'd1);
    end
    @(posedge clk);
    #1;

    // 20 + 3 = 23 held through a stall
    out_ready = 1'b0;
    push_exp(23, 1'b0);
    send(5, 2, 1'b0, 1'b1, 1'b0);
    send(3, 0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_cnt   = 4'd2;
    in_shift = '0;
    in_neg   = 1'b0;
    in_first = 1'b1;
    in_last  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 32'd0);
      check("stall_valid", out_valid, 32'd1);
      check("stall_data", out_data, 32'd23);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_exp(2, 1'b0);
    @(negedge clk);
    check("unstall_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("unstall_data", out_data, 32'd2);
    check("unstall_valid", out_valid, 32'd1);

    // 2 * (15<<15) = 983040 fits
    push_exp(983040, 1'b0);
    send(15, 15, 1'b0, 1'b1, 1'b0);
    send(15, 15, 1'b0, 1'b0, 1'b1);
    // 18 * 491520 = 8847360 wraps to -7929856
    push_exp(-7929856, 1'b1);
    for (int i = 0; i < 18; i++)
      send(15, 15, 1'b0, (i == 0), (i == 17));
    push_exp(1, 1'b0);
    send(1, 0, 1'b0, 1'b1, 1'b1);

    // beat without first while idle: 4<<1 = 8, error pulse
    push_exp(8, 1'b0);
    send(4, 1, 1'b0, 1'b0, 1'b1);
    check("err_pulse", err_frame, 32'd1);
    @(posedge clk);
    #1;
    check("err_clear", err_frame, 32'd0);

    // mid-frame first restarts: result is 2<<1 = 4 only
    push_exp(4, 1'b0);
    send(7, 0, 1'b0, 1'b1, 1'b0);
    check("restart_no_err_a", err_frame, 32'd0);
    send(2, 1, 1'b0, 1'b1, 1'b1);
    check("restart_no_err_b", err_frame, 32'd0);
    @(posedge clk);
    #1;

    // reset mid-frame discards it; a first-less beat then starts fresh
    send(9, 0, 1'b0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 32'd0);
    check("rst_mid_in_ready", in_ready, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(3, 1'b0);
    send(3, 0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_err", err_frame, 32'd1);
    @(posedge clk);
    #1;

    // reset while a result is pending
    out_ready = 1'b0;
    send(6, 0, 1'b0, 1'b1, 1'b1);
    check("pend_valid", out_valid, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_pend_valid", out_valid, 32'd0);
    check("rst_pend_data", out_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    push_exp(2, 1'b0);
    send(2, 0, 1'b0, 1'b1, 1'b1);
    check("post_rst_data", out_data, 32'd2);

    repeat (3) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
